// File: rtl/gpu_cdb_pkg.sv
// gpu_cdb_pkg: shared widths and the CDB result record carried by the writeback path
package gpu_cdb_pkg;
  localparam int NUM_LANES = 8;
  localparam int LANE_W = 32;
  localparam int WARP_W = 3;
  localparam int REG_W = 5;
  localparam int SCB_W = 2;
  localparam int INSTR_W = 32;
  localparam int DATA_W = NUM_LANES * LANE_W;
  typedef struct packed {
    logic regwrite;
    logic [NUM_LANES-1:0] mask;
    logic [INSTR_W-1:0] instr;
    logic [WARP_W-1:0] warp;
    logic [REG_W-1:0] dst;
    logic [DATA_W-1:0] data;
    logic [SCB_W-1:0] scbid;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_mem_fifo.sv
// cdb_mem_fifo: in-order sync FIFO of MEM results; caller never pushes when full or pops when empty
module cdb_mem_fifo
  import gpu_cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  cdb_entry_t    din_i,
  input  logic          pop_i,
  output cdb_entry_t    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  cdb_entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o = mem_q[rd_q];
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks ALU (priority) or queued MEM result each cycle and broadcasts it on the CDB
module cdb_arbiter
  import gpu_cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWrite_ALU_CDB,
  input  logic [NUM_LANES-1:0] ActiveMask_ALU_CDB,
  input  logic [INSTR_W-1:0]   Instr_ALU_CDB,
  input  logic [WARP_W-1:0]    WarpID_ALU_CDB,
  input  logic [REG_W-1:0]     Dst_ALU_CDB,
  input  logic [DATA_W-1:0]    Dst_Data_ALU_CDB,
  input  logic [SCB_W-1:0]     Clear_ScbID_ALU_CDB,
  input  logic                 Valid_MEM_CDB,
  output logic                 Ready_CDB_MEM,
  input  logic                 RegWrite_MEM_CDB,
  input  logic [NUM_LANES-1:0] ActiveMask_MEM_CDB,
  input  logic [INSTR_W-1:0]   Instr_MEM_CDB,
  input  logic [WARP_W-1:0]    WarpID_MEM_CDB,
  input  logic [REG_W-1:0]     Dst_MEM_CDB,
  input  logic [DATA_W-1:0]    Dst_Data_MEM_CDB,
  input  logic [SCB_W-1:0]     ScbID_MEM_CDB,
  output logic                 Valid_CDB,
  output logic                 RegWrite_CDB,
  output logic [NUM_LANES-1:0] ActiveMask_CDB,
  output logic [INSTR_W-1:0]   Instr_CDB,
  output logic [WARP_W-1:0]    WarpID_CDB,
  output logic [REG_W-1:0]     Dst_CDB,
  output logic [DATA_W-1:0]    Dst_Data_CDB,
  output logic [SCB_W-1:0]     Clear_ScbID_CDB,
  output logic                 Src_CDB,
  output logic                 Hold_CDB_Issue
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] NEAR_FULL = CW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  cdb_entry_t alu_e, mem_e, head, out_q, out_d;
  logic valid_q, valid_d, src_q, src_d, full, empty, push, pop;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] count;
  assign alu_e = '{regwrite: 1'b1, mask: ActiveMask_ALU_CDB, instr: Instr_ALU_CDB,
                   warp: WarpID_ALU_CDB, dst: Dst_ALU_CDB, data: Dst_Data_ALU_CDB,
                   scbid: Clear_ScbID_ALU_CDB};
  assign mem_e = '{regwrite: RegWrite_MEM_CDB, mask: ActiveMask_MEM_CDB, instr: Instr_MEM_CDB,
                   warp: WarpID_MEM_CDB, dst: Dst_MEM_CDB, data: Dst_Data_MEM_CDB,
                   scbid: ScbID_MEM_CDB};
  assign Ready_CDB_MEM = rst & ~full;
  assign push = Valid_MEM_CDB & Ready_CDB_MEM;
  assign pop = rst & ~RegWrite_ALU_CDB & ~empty;
  cdb_mem_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .din_i(mem_e), .pop_i(pop),
    .dout_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  // Idle cycles keep the old payload but must never signal a register write.
  always_comb begin
    out_d = RegWrite_ALU_CDB ? alu_e : empty ? out_q : head;
    out_d.regwrite = out_d.regwrite & (RegWrite_ALU_CDB | ~empty);
    valid_d = RegWrite_ALU_CDB | ~empty;
    src_d = RegWrite_ALU_CDB ? 1'b0 : empty ? src_q : 1'b1;
    starve_d = (empty | ~RegWrite_ALU_CDB) ? '0 : starve_q + SW'(starve_q != SMAX);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= '0;
      valid_q <= 1'b0;
      src_q <= 1'b0;
      starve_q <= '0;
    end else begin
      out_q <= out_d;
      valid_q <= valid_d;
      src_q <= src_d;
      starve_q <= starve_d;
    end
  end
  assign Valid_CDB = valid_q;
  assign RegWrite_CDB = valid_q & out_q.regwrite;
  assign ActiveMask_CDB = out_q.mask;
  assign Instr_CDB = out_q.instr;
  assign WarpID_CDB = out_q.warp;
  assign Dst_CDB = out_q.dst;
  assign Dst_Data_CDB = out_q.data;
  assign Clear_ScbID_CDB = out_q.scbid;
  assign Src_CDB = src_q;
  assign Hold_CDB_Issue = (starve_q >= SMAX) | (count >= NEAR_FULL);
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven per-cycle vectors plus directed starvation and reset-mid-drain sequences
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic RegWrite_ALU_CDB, Valid_MEM_CDB, Ready_CDB_MEM, RegWrite_MEM_CDB;
  logic [7:0] ActiveMask_ALU_CDB, ActiveMask_MEM_CDB, ActiveMask_CDB;
  logic [31:0] Instr_ALU_CDB, Instr_MEM_CDB, Instr_CDB;
  logic [2:0] WarpID_ALU_CDB, WarpID_MEM_CDB, WarpID_CDB;
  logic [4:0] Dst_ALU_CDB, Dst_MEM_CDB, Dst_CDB;
  logic [255:0] Dst_Data_ALU_CDB, Dst_Data_MEM_CDB, Dst_Data_CDB;
  logic [1:0] Clear_ScbID_ALU_CDB, ScbID_MEM_CDB, Clear_ScbID_CDB;
  logic Valid_CDB, RegWrite_CDB, Src_CDB, Hold_CDB_Issue;
  int n_chk = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .RegWrite_ALU_CDB(RegWrite_ALU_CDB), .ActiveMask_ALU_CDB(ActiveMask_ALU_CDB),
    .Instr_ALU_CDB(Instr_ALU_CDB), .WarpID_ALU_CDB(WarpID_ALU_CDB), .Dst_ALU_CDB(Dst_ALU_CDB),
    .Dst_Data_ALU_CDB(Dst_Data_ALU_CDB), .Clear_ScbID_ALU_CDB(Clear_ScbID_ALU_CDB),
    .Valid_MEM_CDB(Valid_MEM_CDB), .Ready_CDB_MEM(Ready_CDB_MEM), .RegWrite_MEM_CDB(RegWrite_MEM_CDB),
    .ActiveMask_MEM_CDB(ActiveMask_MEM_CDB), .Instr_MEM_CDB(Instr_MEM_CDB),
    .WarpID_MEM_CDB(WarpID_MEM_CDB), .Dst_MEM_CDB(Dst_MEM_CDB), .Dst_Data_MEM_CDB(Dst_Data_MEM_CDB),
    .ScbID_MEM_CDB(ScbID_MEM_CDB), .Valid_CDB(Valid_CDB), .RegWrite_CDB(RegWrite_CDB),
    .ActiveMask_CDB(ActiveMask_CDB), .Instr_CDB(Instr_CDB), .WarpID_CDB(WarpID_CDB),
    .Dst_CDB(Dst_CDB), .Dst_Data_CDB(Dst_Data_CDB), .Clear_ScbID_CDB(Clear_ScbID_CDB),
    .Src_CDB(Src_CDB), .Hold_CDB_Issue(Hold_CDB_Issue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, av, ad, as, mv, mr, md, ms;
    int ev, erw, es, ed, esc, erd, eh;
  } vec_t;
  vec_t tv[$];

  // Payload fields other than dst/scb are derived from (source, dst) so each result is recognisable.
  function automatic logic [7:0] mk_mask(input logic s, input logic [4:0] d);
    return {s, 2'b01, d};
  endfunction
  function automatic logic [31:0] mk_instr(input logic s, input logic [4:0] d);
    return {s, 26'h2AAAAAA, d};
  endfunction
  function automatic logic [2:0] mk_warp(input logic [4:0] d);
    return d[2:0] ^ 3'd6;
  endfunction
  function automatic logic [255:0] mk_data(input logic s, input logic [4:0] d);
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = 32'(d) + 32'(i * 16) + (s ? 32'h1000 : 32'h0) + 32'd2;
    return x;
  endfunction

  function automatic vec_t v(input int r, av, ad, as, mv, mr, md, ms, ev, erw, es, ed, esc, erd, eh);
    vec_t t;
    t = '{r, av, ad, as, mv, mr, md, ms, ev, erw, es, ed, esc, erd, eh};
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic set_in(input int r, av, ad, as, mv, mr, md, ms);
    rst = 1'(r);
    RegWrite_ALU_CDB = 1'(av);
    Dst_ALU_CDB = 5'(ad);
    Clear_ScbID_ALU_CDB = 2'(as);
    ActiveMask_ALU_CDB = mk_mask(1'b0, 5'(ad));
    Instr_ALU_CDB = mk_instr(1'b0, 5'(ad));
    WarpID_ALU_CDB = mk_warp(5'(ad));
    Dst_Data_ALU_CDB = mk_data(1'b0, 5'(ad));
    Valid_MEM_CDB = 1'(mv);
    RegWrite_MEM_CDB = 1'(mr);
    Dst_MEM_CDB = 5'(md);
    ScbID_MEM_CDB = 2'(ms);
    ActiveMask_MEM_CDB = mk_mask(1'b1, 5'(md));
    Instr_MEM_CDB = mk_instr(1'b1, 5'(md));
    WarpID_MEM_CDB = mk_warp(5'(md));
    Dst_Data_MEM_CDB = mk_data(1'b1, 5'(md));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string n, input int ev, es, ed);
    logic [255:0] d;
    d = mk_data(1'(es), 5'(ed));
    chk({n, " valid"}, 32'(Valid_CDB), ev);
    if (ev != 0) begin
      chk({n, " src"}, 32'(Src_CDB), es);
      chk({n, " dst"}, 32'(Dst_CDB), ed);
      chk({n, " mask"}, 32'(ActiveMask_CDB), 32'(mk_mask(1'(es), 5'(ed))));
      chk({n, " instr"}, Instr_CDB, mk_instr(1'(es), 5'(ed)));
      chk({n, " warp"}, 32'(WarpID_CDB), 32'(mk_warp(5'(ed))));
      chk({n, " lane0"}, Dst_Data_CDB[31:0], d[31:0]);
      chk({n, " lane7"}, Dst_Data_CDB[255:224], d[255:224]);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, " valid"}, 32'(Valid_CDB), 0);
    chk({n, " regwrite"}, 32'(RegWrite_CDB), 0);
    chk({n, " src"}, 32'(Src_CDB), 0);
    chk({n, " dst"}, 32'(Dst_CDB), 0);
    chk({n, " scb"}, 32'(Clear_ScbID_CDB), 0);
    chk({n, " mask"}, 32'(ActiveMask_CDB), 0);
    chk({n, " lane0"}, Dst_Data_CDB[31:0], 0);
    chk({n, " ready"}, 32'(Ready_CDB_MEM), 0);
    chk({n, " hold"}, 32'(Hold_CDB_Issue), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tv.push_back(v(0,1,1,1,1,1,1,1, 0,0,0,0,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    tv.push_back(v(1,1,5,2,0,0,0,0, 1,1,0,5,2,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    tv.push_back(v(1,0,0,0,1,0,6,1, 0,0,0,0,0,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 1,0,1,6,1,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    tv.push_back(v(1,1,4,0,1,1,9,3, 1,1,0,4,0,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 1,1,1,9,3,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    tv.push_back(v(1,1,16,0,1,1,1,1, 1,1,0,16,0,1,0));
    tv.push_back(v(1,1,17,1,1,1,2,2, 1,1,0,17,1,1,0));
    tv.push_back(v(1,1,18,2,1,1,3,3, 1,1,0,18,2,1,1));
    tv.push_back(v(1,1,19,3,1,1,4,0, 1,1,0,19,3,0,1));
    for (int k = 20; k < 26; k++) tv.push_back(v(1,1,k,k%4,1,1,5,1, 1,1,0,k,k%4,0,1));
    tv.push_back(v(1,0,0,0,1,1,5,1, 1,1,1,1,1,1,1));
    tv.push_back(v(1,0,0,0,1,1,5,1, 1,1,1,2,2,1,1));
    tv.push_back(v(1,0,0,0,0,0,0,0, 1,1,1,3,3,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 1,1,1,4,0,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 1,1,1,5,1,1,0));
    tv.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    for (int i = 0; i < tv.size(); i++) begin
      vec_t t;
      string n;
      t = tv[i];
      n = $sformatf("row%0d", i);
      set_in(t.r, t.av, t.ad, t.as, t.mv, t.mr, t.md, t.ms);
      tick;
      if (t.r == 0) chk_zero(n);
      else begin
        chk_out(n, t.ev, t.es, t.ed);
        chk({n, " regwrite"}, 32'(RegWrite_CDB), t.erw);
        if (t.ev != 0) chk({n, " scb"}, 32'(Clear_ScbID_CDB), t.esc);
        chk({n, " ready"}, 32'(Ready_CDB_MEM), t.erd);
        chk({n, " hold"}, 32'(Hold_CDB_Issue), t.eh);
      end
    end
    // Starvation: one queued load loses to a continuous ALU stream.
    set_in(1, 1, 10, 0, 1, 1, 11, 2);
    tick;
    chk("starve push hold", 32'(Hold_CDB_Issue), 0);
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 1, 10, 0, 0, 0, 0, 0);
      tick;
      chk($sformatf("starve lost%0d hold", k), 32'(Hold_CDB_Issue), (k == 4) ? 1 : 0);
      chk_out($sformatf("starve lost%0d", k), 1, 0, 10);
    end
    set_in(1, 1, 10, 0, 0, 0, 0, 0);
    tick;
    chk("starve alu during hold", 32'(Hold_CDB_Issue), 1);
    chk_out("starve alu during hold", 1, 0, 10);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_out("starve pop", 1, 1, 11);
    chk("starve pop scb", 32'(Clear_ScbID_CDB), 2);
    chk("starve pop hold", 32'(Hold_CDB_Issue), 0);
    // Reset mid-drain: queue three, drain one, then reset for a single edge.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 28 + k, 0, 1, 1, 12 + k, 0);
      tick;
    end
    chk("middrain queued hold", 32'(Hold_CDB_Issue), 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_out("middrain pop", 1, 1, 12);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_zero("middrain reset");
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      tick;
      chk($sformatf("middrain after%0d valid", k), 32'(Valid_CDB), 0);
      chk($sformatf("middrain after%0d ready", k), 32'(Ready_CDB_MEM), 1);
      chk($sformatf("middrain after%0d hold", k), 32'(Hold_CDB_Issue), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
